la_instr_encoder: RTL and testbench

- Converts field-level instruction requests (format, minor op, registers, immediate) into 32-bit LA32R words bit-compatible with the pipeline's control decoder.
- Sits between the self-test/boot sequencer and the instruction buffer.
- Requests arrive over a valid/ready handshake.
- Encoded words are buffered in a small FIFO and drained over a second valid/ready handshake.

---
 rtl/la_enc_pkg.sv | 43 ++++
 rtl/la_enc_fifo.sv | 53 +++++
 rtl/la_instr_encoder.sv | 145 ++++++++++++++
 tb/tb_la_instr_encoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_enc_pkg.sv
// Shared format codes, opcode prefixes and minor-op constants for the LA32R encoder.
package la_enc_pkg;

    // Code 7 carries the 26-bit jumps (b/bl).
    typedef enum logic [2:0] {
        F_3R   = 3'd0,
        F_SHI  = 3'd1,
        F_RI12 = 3'd2,
        F_MEM  = 3'd3,
        F_RI20 = 3'd4,
        F_BR   = 3'd5,
        F_JIRL = 3'd6,
        F_J26  = 3'd7
    } fmt_e;

    localparam logic [11:0] OP_3R        = 12'h001;
    localparam logic [11:0] OP_SHI       = 12'h004;
    localparam logic [6:0]  OP_RI12      = 7'b0000001;
    localparam logic [6:0]  OP_LU12I     = 7'b0001010;
    localparam logic [6:0]  OP_PCADDU12I = 7'b0001110;
    localparam logic [5:0]  OP_MEM       = 6'b001010;
    localparam logic [5:0]  OP_BEQ       = 6'b010110;
    localparam logic [5:0]  OP_JIRL      = 6'b010011;
    localparam logic [5:0]  OP_B         = 6'b010100;
    localparam logic [5:0]  OP_BL        = 6'b010101;

    localparam logic [4:0] M_ADD  = 5'b00000, M_SUB = 5'b00010, M_SLT = 5'b00100;
    localparam logic [4:0] M_SLTU = 5'b00101, M_NOR = 5'b01000, M_AND = 5'b01001;
    localparam logic [4:0] M_OR   = 5'b01010, M_XOR = 5'b01011, M_SLL = 5'b01110;
    localparam logic [4:0] M_SRL  = 5'b01111, M_SRA = 5'b10000;

    localparam logic [1:0] M_SLLI = 2'b00, M_SRLI = 2'b01, M_SRAI = 2'b10;

    localparam logic [2:0] M_SLTI = 3'b000, M_SLTUI = 3'b001, M_ADDI = 3'b010;
    localparam logic [2:0] M_ANDI = 3'b101, M_ORI   = 3'b110, M_XORI = 3'b111;

    localparam logic [3:0] M_LDB  = 4'b0000, M_LDH  = 4'b0001, M_LDW = 4'b0010;
    localparam logic [3:0] M_STB  = 4'b0100, M_STH  = 4'b0101, M_STW = 4'b0110;
    localparam logic [3:0] M_LDBU = 4'b1000, M_LDHU = 4'b1001;

    localparam logic [2:0] M_BGEU = 3'd5;

endpackage

// File: rtl/la_enc_fifo.sv
// Output word FIFO: power-of-two depth, wrapping pointers, flush clears occupancy.
module la_enc_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // An empty FIFO presents zero rather than stale storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/la_instr_encoder.sv
// Field-level request -> LA32R instruction word encoder with output FIFO.
// Optional build macro IMM_RANGE_CHECK_EN rejects immediates that overflow their field.
module la_instr_encoder
    import la_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fmt,
    input  logic [4:0]       req_minor,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rj,
    input  logic [4:0]       req_rk,
    input  logic [31:0]      req_imm,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [31:0]      ins_word,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic        rst_q;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        op_ok;
    logic        imm_ok;
    logic        legal;
    logic [31:0] word;
    logic [25:0] offs;
    logic        aligned;

    assign offs    = req_imm[27:2];
    assign aligned = (req_imm[1:0] == 2'b00);

    always_comb begin
        word  = '0;
        op_ok = 1'b0;
        case (fmt_e'(req_fmt))
            F_3R: begin
                word  = {OP_3R, req_minor, req_rk, req_rj, req_rd};
                op_ok = req_minor inside {M_ADD, M_SUB, M_SLT, M_SLTU, M_NOR, M_AND,
                                          M_OR, M_XOR, M_SLL, M_SRL, M_SRA};
            end
            F_SHI: begin
                word  = {OP_SHI, req_minor[1:0], 3'b001, req_imm[4:0], req_rj, req_rd};
                op_ok = req_minor[1:0] inside {M_SLLI, M_SRLI, M_SRAI};
            end
            F_RI12: begin
                word  = {OP_RI12, req_minor[2:0], req_imm[11:0], req_rj, req_rd};
                op_ok = req_minor[2:0] inside {M_SLTI, M_SLTUI, M_ADDI, M_ANDI, M_ORI, M_XORI};
            end
            F_MEM: begin
                word  = {OP_MEM, req_minor[3:0], req_imm[11:0], req_rj, req_rd};
                op_ok = req_minor[3:0] inside {M_LDB, M_LDH, M_LDW, M_STB, M_STH, M_STW,
                                               M_LDBU, M_LDHU};
            end
            F_RI20: begin
                word  = {req_minor[0] ? OP_PCADDU12I : OP_LU12I, req_imm[19:0], req_rd};
                op_ok = 1'b1;
            end
            F_BR: begin
                word  = {OP_BEQ + {3'b000, req_minor[2:0]}, offs[15:0], req_rj, req_rd};
                op_ok = (req_minor[2:0] <= M_BGEU) & aligned;
            end
            F_JIRL: begin
                word  = {OP_JIRL, offs[15:0], req_rj, req_rd};
                op_ok = aligned;
            end
            F_J26: begin
                word  = {req_minor[0] ? OP_BL : OP_B, offs[15:0], offs[25:16]};
                op_ok = aligned;
            end
            default: begin
                word  = '0;
                op_ok = 1'b0;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        imm_ok = 1'b1;
        case (fmt_e'(req_fmt))
            F_SHI:  imm_ok = (req_imm <= 32'd31);
            F_RI12: imm_ok = (req_minor[2:0] inside {M_ANDI, M_ORI, M_XORI})
                             ? (req_imm <= 32'd4095)
                             : ($signed(req_imm) >= -32'sd2048) && ($signed(req_imm) <= 32'sd2047);
            F_MEM:  imm_ok = ($signed(req_imm) >= -32'sd2048) && ($signed(req_imm) <= 32'sd2047);
            F_RI20: imm_ok = (req_imm[31:20] == 12'h000);
            F_BR, F_JIRL:
                    imm_ok = ($signed(req_imm) >= -32'sd131072) && ($signed(req_imm) <= 32'sd131071);
            F_J26:  imm_ok = ($signed(req_imm) >= -32'sd134217728) && ($signed(req_imm) <= 32'sd134217727);
            default: imm_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^req_imm[31:28];
    assign imm_ok        = 1'b1;
`endif

    assign legal     = op_ok & imm_ok;
    assign req_ready = ~full & ~flush & ~rst_q;
    assign accept    = req_valid & req_ready;
    assign push      = accept & legal;
    assign ins_valid = ~empty;

    // Control state: reset-qualified ready, error pulse and statistics.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            err     <= 1'b0;
            enc_cnt <= '0;
            err_cnt <= '0;
        end else begin
            err <= accept & ~legal;
            if (push) enc_cnt <= enc_cnt + 1'b1;
            if (accept && !legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    la_enc_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (word),
        .pop   (ins_ready),
        .dout  (ins_word),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_la_instr_encoder.sv
// Scoreboard bench for la_instr_encoder: expected words queued at accept, compared at pop.
module tb_la_instr_encoder;
    import la_enc_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, flush, req_valid, req_ready, ins_valid, ins_ready, err;
    logic [2:0]       req_fmt;
    logic [4:0]       req_minor, req_rd, req_rj, req_rk;
    logic [31:0]      req_imm, ins_word;
    logic [CNT_W-1:0] enc_cnt, err_cnt;

    int          errors = 0;
    int          checks = 0;
    int          exp_enc = 0;
    int          exp_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  minor;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    always #5 clk = ~clk;

    la_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_minor(req_minor), .req_rd(req_rd),
        .req_rj(req_rj), .req_rk(req_rk), .req_imm(req_imm),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
        .err(err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    task automatic set_req(input logic [2:0] fmt, input logic [4:0] minor, input logic [4:0] rd,
                           input logic [4:0] rj, input logic [4:0] rk, input logic [31:0] imm);
        req_fmt = fmt; req_minor = minor; req_rd = rd; req_rj = rj; req_rk = rk; req_imm = imm;
        req_valid = 1'b1;
    endtask

    // addi.w rd=i+1, rj=2, imm=4*i
    function automatic logic [31:0] addi_word(input int i);
        return 32'h02800000 | (32'(i * 4) << 10) | (32'd2 << 5) | 32'(i + 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; ins_ready = 1'b0;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid: got %b want 0", ins_valid); end
        checks++; if (ins_word !== 32'd0) begin errors++; $display("FAIL rst_ins_word: got %h want 0", ins_word); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (enc_cnt !== '0) begin errors++; $display("FAIL rst_enc_cnt: got %0d want 0", enc_cnt); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL dead_cycle_ready: got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_encodings();
        vec_t        v[$];
        logic [31:0] exp;
        v.push_back('{F_3R,   5'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h00100823});
        v.push_back('{F_RI12, 5'd2, 5'd4, 5'd0, 5'd0, 32'hFFFFFFFF,   32'h02BFFC04});
        v.push_back('{F_RI20, 5'd0, 5'd5, 5'd0, 5'd0, 32'h00012345,   32'h142468A5});
        v.push_back('{F_BR,   5'd0, 5'd2, 5'd1, 5'd0, 32'd8,          32'h58000822});
        v.push_back('{F_J26,  5'd1, 5'd7, 5'd0, 5'd0, 32'h00000100,   32'h54010000});
        foreach (v[i]) begin
            set_req(v[i].fmt, v[i].minor, v[i].rd, v[i].rj, v[i].rk, v[i].imm);
            exp_q.push_back(v[i].word);
            @(negedge clk);
            req_valid = 1'b0; ins_ready = 1'b1; exp_enc++;
            checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL enc%0d_valid: got %b want 1", i, ins_valid); end
            exp = exp_q.pop_front();
            checks++; if (ins_word !== exp) begin errors++; $display("FAIL enc%0d_word: got %h want %h", i, ins_word, exp); end
            checks++; if (enc_cnt !== CNT_W'(exp_enc)) begin errors++; $display("FAIL enc%0d_cnt: got %0d want %0d", i, enc_cnt, exp_enc); end
            @(negedge clk);
            ins_ready = 1'b0;
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL enc%0d_drained: got %b want 0", i, ins_valid); end
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back('{F_BR,   5'd0, 5'd2, 5'd1, 5'd0, 32'd6, 32'd0});
        v.push_back('{F_3R,   5'd1, 5'd2, 5'd1, 5'd3, 32'd0, 32'd0});
        v.push_back('{F_RI12, 5'd3, 5'd2, 5'd1, 5'd0, 32'd5, 32'd0});
        foreach (v[i]) begin
            set_req(v[i].fmt, v[i].minor, v[i].rd, v[i].rj, v[i].rk, v[i].imm);
            @(negedge clk);
            req_valid = 1'b0; exp_err++;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill%0d_err: got %b want 1", i, err); end
            checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL ill%0d_nopush: got %b want 0", i, ins_valid); end
            checks++; if (err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL ill%0d_err_cnt: got %0d want %0d", i, err_cnt, exp_err); end
            @(negedge clk);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill%0d_pulse: got %b want 0", i, err); end
        end
        checks++; if (enc_cnt !== CNT_W'(exp_enc)) begin errors++; $display("FAIL ill_enc_cnt: got %0d want %0d", enc_cnt, exp_enc); end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          popped = 0;
        int          both = 0;
        bit          will_pop, will_push;
        logic [31:0] exp;
        ins_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_req(F_RI12, 5'd2, 5'(i + 1), 5'd2, 5'd0, 32'(i * 4));
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill%0d_ready: got %b want 1", i, req_ready); end
            @(negedge clk);
            exp_q.push_back(addi_word(i)); exp_enc++; sent++;
        end
        set_req(F_RI12, 5'd2, 5'(sent + 1), 5'd2, 5'd0, 32'(sent * 4));
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
        checks++; if (ins_word !== exp_q[0]) begin errors++; $display("FAIL full_head: got %h want %h", ins_word, exp_q[0]); end
        @(negedge clk);
        checks++; if (ins_word !== exp_q[0]) begin errors++; $display("FAIL head_hold: got %h want %h", ins_word, exp_q[0]); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold: got %b want 0", req_ready); end
        ins_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && (sent < 8 || exp_q.size() > 0); cyc++) begin
            will_pop  = ins_valid;
            will_push = req_valid && req_ready;
            if (will_pop) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra: got %h want no word", ins_word);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (ins_word !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", popped, ins_word, exp); end
                end
                popped++;
            end
            if (will_push) begin
                exp_q.push_back(addi_word(sent)); sent++; exp_enc++;
            end
            if (will_pop && will_push) both++;
            @(negedge clk);
            if (sent < 8) set_req(F_RI12, 5'd2, 5'(sent + 1), 5'd2, 5'd0, 32'(sent * 4));
            else req_valid = 1'b0;
        end
        ins_ready = 1'b0;
        checks++; if (popped != 8) begin errors++; $display("FAIL b2b_popped: got %0d want 8", popped); end
        checks++; if (both == 0) begin errors++; $display("FAIL b2b_overlap: got %0d want >0", both); end
        checks++; if (enc_cnt !== CNT_W'(exp_enc)) begin errors++; $display("FAIL b2b_enc_cnt: got %0d want %0d", enc_cnt, exp_enc); end
        exp_q.delete();
    endtask

    task automatic test_flush();
        ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(F_RI12, 5'd2, 5'(i + 1), 5'd2, 5'd0, 32'(i * 4));
            @(negedge clk);
            exp_enc++;
        end
        req_valid = 1'b0;
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", ins_valid); end
        flush = 1'b1; ins_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        @(negedge clk);
        flush = 1'b0; ins_ready = 1'b0;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ins_valid); end
        checks++; if (ins_word !== 32'd0) begin errors++; $display("FAIL flush_word: got %h want 0", ins_word); end
        checks++; if (enc_cnt !== CNT_W'(exp_enc)) begin errors++; $display("FAIL flush_enc_cnt: got %0d want %0d", enc_cnt, exp_enc); end
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_imm_range();
        logic [31:0] exp;
        set_req(F_RI12, 5'd2, 5'd1, 5'd2, 5'd0, 32'd2048);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        exp_err++;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", err); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL range_nopush: got %b want 0", ins_valid); end
        checks++; if (err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL range_err_cnt: got %0d want %0d", err_cnt, exp_err); end
`else
        exp_enc++;
        exp_q.push_back(32'h02A00041);
        ins_ready = 1'b1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL trunc_err: got %b want 0", err); end
        exp = exp_q.pop_front();
        checks++; if (ins_word !== exp) begin errors++; $display("FAIL trunc_word: got %h want %h", ins_word, exp); end
`endif
        @(negedge clk);
        ins_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ins_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(F_3R, 5'd0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        set_req(F_3R, 5'd0, 5'd9, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        exp_enc = 0; exp_err = 0; exp_q.delete();
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", ins_valid); end
        checks++; if (ins_word !== 32'd0) begin errors++; $display("FAIL mid_rst_word: got %h want 0", ins_word); end
        checks++; if (enc_cnt !== '0) begin errors++; $display("FAIL mid_rst_enc_cnt: got %0d want 0", enc_cnt); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL mid_rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", err); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_back: got %b want 1", req_ready); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_push_dropped: got %b want 0", ins_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_encodings();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_imm_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
